// File: rtl/cronometro_pkg.sv
// rtl/cronometro_pkg.sv - shared state encoding and digit constants for the stopwatch controller
package cronometro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_FULL  = 3'd4
  } state_t;

  localparam int UNIT_W   = 4;
  localparam int TENS_W   = 3;
  localparam int UNIT_MAX = 9;
  localparam int TENS_MAX = 5;

  typedef struct packed {
    logic [TENS_W-1:0] mt;
    logic [UNIT_W-1:0] mu;
    logic [TENS_W-1:0] st;
    logic [UNIT_W-1:0] su;
  } digits_t;

endpackage

// File: rtl/bcd_contador.sv
// rtl/bcd_contador.sv - single BCD digit counter with registered terminal flag, falling-edge clocked
module bcd_contador #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         ck,
  input  logic         rst_s,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_max
);

  // at_max is registered alongside q so the cascade never sees a combinational compare
  always_ff @(negedge ck) begin
    if (rst_s) begin
      q      <= '0;
      at_max <= 1'b0;
    end else if (en) begin
      if (at_max) begin
        q      <= '0;
        at_max <= 1'b0;
      end else begin
        q      <= q + 1'b1;
        at_max <= (q == W'(MAX - 1));
      end
    end
  end

endmodule

// File: rtl/cronometro_presc.sv
// rtl/cronometro_presc.sv - base tick prescaler producing the one-second enable
module cronometro_presc #(
  parameter int PRESC = 10,
  parameter int PW    = 8
) (
  input  logic ck,
  input  logic rst_s,
  input  logic en,
  input  logic tick,
  output logic sec_en
);

  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] cnt;

  assign sec_en = en & tick & (cnt == LAST);

  always_ff @(negedge ck) begin
    if (rst_s) begin
      cnt <= '0;
    end else if (en && tick) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cronometro_ctrl.sv
// rtl/cronometro_ctrl.sv - stopwatch run/pause/lap/clear sequencer over four BCD digit counters
module cronometro_ctrl
  import cronometro_pkg::*;
#(
  parameter int PRESC = 10,
  parameter int PW    = 8
) (
  input  logic              ck,
  input  logic              rst_s,
  input  logic              tick,
  input  logic              start_stop,
  input  logic              lap,
  input  logic              clear,
  output logic              running,
  output logic              lap_active,
  output logic              overflow,
  output logic [UNIT_W-1:0] disp_su,
  output logic [TENS_W-1:0] disp_st,
  output logic [UNIT_W-1:0] disp_mu,
  output logic [TENS_W-1:0] disp_mt
);

  state_t  state, state_nx;
  digits_t live, lap_q, shown;
  logic    sec_en, live_en, clr_go, cnt_rst;
  logic    su_max, st_max, mu_max, mt_max, all_max, sat;
  logic    su_en, st_en, mu_en, mt_en, lap_take;

  assign live_en = (state == ST_RUN) || (state == ST_LAP);
  assign clr_go  = clear && ((state == ST_PAUSE) || (state == ST_FULL));
  assign cnt_rst = rst_s | clr_go;

  cronometro_presc #(.PRESC(PRESC), .PW(PW)) u_presc (
    .ck     (ck),
    .rst_s  (cnt_rst),
    .en     (live_en),
    .tick   (tick),
    .sec_en (sec_en)
  );

  // At 59:59 the whole cascade is gated off so the count saturates instead of wrapping
  assign all_max = su_max & st_max & mu_max & mt_max;
  assign sat     = sec_en & all_max;
  assign su_en   = sec_en & ~all_max;
  assign st_en   = su_en & su_max;
  assign mu_en   = st_en & st_max;
  assign mt_en   = mu_en & mu_max;

  bcd_contador #(.W(UNIT_W), .MAX(UNIT_MAX)) u_su (
    .ck(ck), .rst_s(cnt_rst), .en(su_en), .q(live.su), .at_max(su_max)
  );
  bcd_contador #(.W(TENS_W), .MAX(TENS_MAX)) u_st (
    .ck(ck), .rst_s(cnt_rst), .en(st_en), .q(live.st), .at_max(st_max)
  );
  bcd_contador #(.W(UNIT_W), .MAX(UNIT_MAX)) u_mu (
    .ck(ck), .rst_s(cnt_rst), .en(mu_en), .q(live.mu), .at_max(mu_max)
  );
  bcd_contador #(.W(TENS_W), .MAX(TENS_MAX)) u_mt (
    .ck(ck), .rst_s(cnt_rst), .en(mt_en), .q(live.mt), .at_max(mt_max)
  );

  always_ff @(negedge ck) begin
    if (rst_s) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start_stop) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (sat)             state_nx = ST_FULL;
        else if (start_stop) state_nx = ST_PAUSE;
        else if (lap)        state_nx = ST_LAP;
      end
      ST_LAP: begin
        if (sat)             state_nx = ST_FULL;
        else if (start_stop) state_nx = ST_PAUSE;
        else if (lap)        state_nx = ST_RUN;
      end
      ST_PAUSE: begin
        if (clear)           state_nx = ST_IDLE;
        else if (start_stop) state_nx = ST_RUN;
      end
      ST_FULL: begin
        if (clear) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Lap snapshot takes the digits as they stand before this edge's count
  assign lap_take = (state == ST_RUN) && lap && !start_stop && !sat;

  always_ff @(negedge ck) begin
    if (cnt_rst) begin
      lap_q <= '0;
    end else if (lap_take) begin
      lap_q <= live;
    end
  end

  always_comb begin
    running    = 1'b0;
    lap_active = 1'b0;
    overflow   = 1'b0;
    shown      = live;
    case (state)
      ST_RUN:  running = 1'b1;
      ST_LAP: begin
        running    = 1'b1;
        lap_active = 1'b1;
        shown      = lap_q;
      end
      ST_FULL: overflow = 1'b1;
      default: ;
    endcase
  end

  assign disp_su = shown.su;
  assign disp_st = shown.st;
  assign disp_mu = shown.mu;
  assign disp_mt = shown.mt;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// tb/tb_cronometro_ctrl.sv - scoreboard bench for the stopwatch controller
module tb_cronometro_ctrl;

  localparam int PRESC = 2;

  logic       ck = 1'b0;
  logic       rst_s = 1'b0;
  logic       tick = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic       running, lap_active, overflow;
  logic [3:0] disp_su, disp_mu;
  logic [2:0] disp_st, disp_mt;

  int checks = 0;
  int errors = 0;

  string       q_name[$];
  logic [16:0] q_val[$];

  cronometro_ctrl #(.PRESC(PRESC), .PW(8)) dut (
    .ck         (ck),
    .rst_s      (rst_s),
    .tick       (tick),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .disp_su    (disp_su),
    .disp_st    (disp_st),
    .disp_mu    (disp_mu),
    .disp_mt    (disp_mt)
  );

  always #5 ck = ~ck;

  // Drive one falling-edge worth of inputs, set up just after the rising edge
  task automatic step(input bit s, input bit l, input bit c, input bit t, input bit r);
    @(posedge ck);
    #1;
    start_stop = s;
    lap        = l;
    clear      = c;
    tick       = t;
    rst_s      = r;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
  endtask

  // Expected display given as MM:SS in decimal, split into BCD digits here
  task automatic expect_out(input string nm, input bit r, input bit l, input bit o,
                            input int mm, input int ss);
    logic [16:0] v;
    @(posedge ck);
    #1;
    start_stop = 0; lap = 0; clear = 0; tick = 0; rst_s = 0;
    v = {r, l, o, 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    q_name.push_back(nm);
    q_val.push_back(v);
  endtask

  initial begin : monitor
    logic [16:0] act, exp_v;
    string       nm;
    forever begin
      @(posedge ck);
      #3;
      if (q_val.size() > 0) begin
        nm    = q_name.pop_front();
        exp_v = q_val.pop_front();
        act   = {running, lap_active, overflow, disp_mt, disp_mu, disp_st, disp_su};
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL %s got r/l/o=%b%b%b %0d%0d:%0d%0d want r/l/o=%b%b%b %0d%0d:%0d%0d",
                   nm, act[16], act[15], act[14], act[13:11], act[10:7], act[6:4], act[3:0],
                   exp_v[16], exp_v[15], exp_v[14], exp_v[13:11], exp_v[10:7], exp_v[6:4], exp_v[3:0]);
        end
      end
    end
  end

  initial begin : stim
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    expect_out("reset", 0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    ticks(20);
    expect_out("count_10s", 1, 0, 0, 0, 10);
    ticks(98);
    expect_out("at_00_59", 1, 0, 0, 0, 59);
    ticks(2);
    expect_out("cascade_01_00", 1, 0, 0, 1, 0);
    ticks(1078);
    expect_out("at_09_59", 1, 0, 0, 9, 59);
    ticks(2);
    expect_out("cascade_10_00", 1, 0, 0, 10, 0);

    step(1, 0, 0, 0, 0);
    expect_out("pause_10_00", 0, 0, 0, 10, 0);
    step(0, 0, 1, 0, 0);
    expect_out("clear_from_pause", 0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    ticks(11);
    step(1, 0, 0, 0, 0);
    expect_out("pause_00_05", 0, 0, 0, 0, 5);
    ticks(10);
    expect_out("pause_holds", 0, 0, 0, 0, 5);
    step(1, 0, 0, 0, 0);
    ticks(1);
    expect_out("resume_phase_kept", 1, 0, 0, 0, 6);

    ticks(1);
    step(1, 0, 0, 1, 0);
    expect_out("stop_tick_counted", 0, 0, 0, 0, 7);
    step(1, 0, 0, 1, 0);
    ticks(1);
    expect_out("start_tick_ignored", 1, 0, 0, 0, 7);
    ticks(1);
    expect_out("after_restart", 1, 0, 0, 0, 8);

    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    ticks(6);
    step(0, 1, 0, 0, 0);
    expect_out("lap_freeze", 1, 1, 0, 0, 3);
    ticks(8);
    expect_out("lap_still_frozen", 1, 1, 0, 0, 3);
    step(0, 1, 0, 0, 0);
    expect_out("lap_release", 1, 0, 0, 0, 7);
    step(0, 0, 1, 0, 0);
    expect_out("clear_in_run_ignored", 1, 0, 0, 0, 7);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    expect_out("lap_ss_beats_lap", 0, 0, 0, 0, 7);
    step(1, 0, 1, 0, 0);
    expect_out("pause_clear_beats_ss", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    expect_out("idle_lap_clear_noop", 0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    ticks(2);
    step(0, 1, 0, 0, 0);
    expect_out("lap_before_reset", 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    expect_out("reset_in_lap", 0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    ticks(7198);
    expect_out("at_59_59", 1, 0, 0, 59, 59);
    ticks(2);
    expect_out("saturate_full", 0, 0, 1, 59, 59);
    ticks(4);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    expect_out("full_holds", 0, 0, 1, 59, 59);
    step(0, 0, 1, 0, 0);
    expect_out("clear_from_full", 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && q_val.size() > 0; i++) @(posedge ck);
    #5;
    if (q_val.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want 0", q_val.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
